mul_div_unit: RTL and testbench

- Iterative RV32M multiply/divide unit for the multi-cycle RISC-V datapath.
- Sits directly downstream of the register file: consumes the RD1/RD2 operand values and returns a 32-bit result for the writeback mux to the register file (WD3).
- Uses a start/busy/done handshake; the main controller stalls while it runs.
- Fixed latency regardless of operands.

---
 rtl/mul_div_unit.sv | 204 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Iterative RV32M multiply/divide unit for the multi-cycle datapath. It takes
// the register-file read operands, runs a fixed 32-iteration shift-add
// multiply or restoring divide, and returns one 32-bit result for the
// writeback mux.
//
// Latency does not depend on the operands. Start is accepted at edge N, done
// is high between edges N+33 and N+34, and IDLE always sits for one cycle
// between two operations.
//
// Ports
//   clk     system clock, rising-edge active
//   rst     asynchronous active-high reset; discards any in-flight operation
//   start   request pulse, sampled only while idle
//   funct3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//           100 DIV, 101 DIVU, 110 REM, 111 REMU
//   opA     rs1 value
//   opB     rs2 value
//   busy    high while the operation is in CALC or FIX
//   done    one-cycle completion pulse
//   result  registered result; holds until the next completion
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2:0]         f3_reg;
    logic [XLEN-1:0]    a_raw_reg;   // original opA, returned for REM by zero
    logic [XLEN-1:0]    op_reg;      // multiplicand (mul) or divisor (div) magnitude
    logic [XLEN-1:0]    acc_reg;     // product high half / partial remainder
    logic [XLEN-1:0]    lo_reg;      // multiplier bits shifting out / quotient bits shifting in
    logic               neg_a_reg;
    logic               neg_b_reg;
    logic               div0_reg;
    logic               ovf_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [XLEN-1:0]    result_reg;

    // Operand decode at acceptance time
    logic               sign_a;
    logic               sign_b;
    logic               neg_a;
    logic               neg_b;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic               is_signed_div;

    always_comb begin
        sign_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
        sign_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg_a  = sign_a && opA[XLEN-1];
        neg_b  = sign_b && opB[XLEN-1];
        // Negating 0x80000000 yields 0x80000000, which is the correct
        // unsigned magnitude, so no extra width is needed.
        a_mag  = neg_a ? (~opA + 1'b1) : opA;
        b_mag  = neg_b ? (~opB + 1'b1) : opB;
        is_signed_div = (funct3 == 3'b100) || (funct3 == 3'b110);
    end

    // One iteration of the selected algorithm
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      r_shift;
    logic               div_ge;
    logic [XLEN-1:0]    div_diff;
    logic [XLEN-1:0]    acc_next;
    logic [XLEN-1:0]    lo_next;

    always_comb begin
        mul_sum  = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, op_reg} : {(XLEN+1){1'b0}});
        r_shift  = {acc_reg, lo_reg[XLEN-1]};
        div_ge   = (r_shift >= {1'b0, op_reg});
        // When the trial subtraction succeeds the difference is below the
        // divisor, so the low XLEN bits carry the whole value.
        div_diff = r_shift[XLEN-1:0] - op_reg;
        if (f3_reg[2]) begin
            acc_next = div_ge ? div_diff : r_shift[XLEN-1:0];
            lo_next  = {lo_reg[XLEN-2:0], div_ge};
        end else begin
            // Carry out of the add becomes the new top bit after the shift.
            acc_next = mul_sum[XLEN:1];
            lo_next  = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0]  prod;
    logic [2*XLEN-1:0]  prod_s;
    logic [XLEN-1:0]    quo_s;
    logic [XLEN-1:0]    rem_s;
    logic [XLEN-1:0]    fix_result;

    always_comb begin
        prod   = {acc_reg, lo_reg};
        prod_s = (neg_a_reg ^ neg_b_reg) ? (~prod + 1'b1) : prod;
        quo_s  = (neg_a_reg ^ neg_b_reg) ? (~lo_reg + 1'b1) : lo_reg;
        rem_s  = neg_a_reg ? (~acc_reg + 1'b1) : acc_reg;
        fix_result = '0;
        case (f3_reg)
            3'b000:  fix_result = prod_s[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  fix_result = prod_s[2*XLEN-1:XLEN];
            3'b100:  fix_result = div0_reg ? {XLEN{1'b1}} :
                                  ovf_reg  ? {1'b1, {(XLEN-1){1'b0}}} : quo_s;
            3'b101:  fix_result = div0_reg ? {XLEN{1'b1}} : quo_s;
            3'b110:  fix_result = div0_reg ? a_raw_reg :
                                  ovf_reg  ? {XLEN{1'b0}} : rem_s;
            default: fix_result = div0_reg ? a_raw_reg : rem_s;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            f3_reg     <= '0;
            a_raw_reg  <= '0;
            op_reg     <= '0;
            acc_reg    <= '0;
            lo_reg     <= '0;
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            div0_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        f3_reg    <= funct3;
                        a_raw_reg <= opA;
                        neg_a_reg <= neg_a;
                        neg_b_reg <= neg_b;
                        // Divide shifts the dividend out of lo_reg; multiply
                        // shifts the multiplier (opB) out of lo_reg.
                        op_reg    <= funct3[2] ? b_mag : a_mag;
                        lo_reg    <= funct3[2] ? a_mag : b_mag;
                        acc_reg   <= '0;
                        div0_reg  <= (opB == '0);
                        ovf_reg   <= is_signed_div &&
                                     (opA == {1'b1, {(XLEN-1){1'b0}}}) &&
                                     (opB == {XLEN{1'b1}});
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    acc_reg <= acc_next;
                    lo_reg  <= lo_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(XLEN-1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    result_reg <= fix_result;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//
// Directed vector table for every funct3 including the divide-by-zero and
// signed-overflow cases, followed by hand-written handshake and mid-operation
// reset sequences. One line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int compared   = 0;
    int mismatched = 0;

    mul_div_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    // Edge count from the start edge to the edge that raises done
    localparam int LAT = 33;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Counts edges from the current point until done is seen, bounded.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        bit busy_ok;
        @(negedge clk);
        funct3 = f;
        opA    = a;
        opB    = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, busy_ok);
        $display("op %-10s f3=%0d a=%h b=%h result=%h exp=%h lat=%0d", name, f, a, b, result, exp, lat);
        check({name, "_result"}, result, exp);
        check({name, "_latency"}, 32'(lat), 32'(LAT));
        check({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        check({name, "_pulse"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int  lat;
        bit  busy_ok;

        vecs[0]  = '{"mulhu_ff",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1]  = '{"mul_ff",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[2]  = '{"mulh_m2x3", 3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
        vecs[3]  = '{"mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{"mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[5]  = '{"mulhu_2^32",3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
        vecs[6]  = '{"div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[7]  = '{"rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[8]  = '{"div_7_m2",  3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[9]  = '{"rem_7_m2",  3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[10] = '{"divu_100_7",3'b101, 32'd100,       32'd7,         32'd14};
        vecs[11] = '{"remu_100_7",3'b111, 32'd100,       32'd7,         32'd2};
        vecs[12] = '{"divu_big",  3'b101, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF};
        vecs[13] = '{"divu_by0",  3'b101, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[14] = '{"rem_by0",   3'b110, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
        vecs[15] = '{"div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[16] = '{"rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        opA    = '0;
        opB    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, result[29:0]}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Handshake: start held high, opA changed mid-operation.
        @(negedge clk);
        funct3 = 3'b101;
        opA    = 32'd100;
        opB    = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) @(posedge clk);
        #1;
        opA = 32'd200;
        wait_done(lat, busy_ok);
        lat += 5;
        $display("op hs_first   f3=5 a=%h b=%h result=%h exp=%h lat=%0d", 32'd100, opB, result, 32'd14, lat);
        check("hs_first_result", result, 32'd14);
        check("hs_first_latency", 32'(lat), 32'(LAT));
        check("hs_first_busy", {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        check("hs_idle_gap", {30'd0, busy, done}, 32'd0);
        @(posedge clk);
        #1;
        check("hs_accept2", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(lat, busy_ok);
        $display("op hs_second  f3=5 a=%h b=%h result=%h exp=%h lat=%0d", 32'd200, opB, result, 32'd28, lat);
        check("hs_second_result", result, 32'd28);
        check("hs_second_latency", 32'(lat), 32'(LAT));
        @(posedge clk);
        #1;

        // Reset in the middle of a DIV.
        @(negedge clk);
        funct3 = 3'b100;
        opA    = 32'hFFFF_FFF9;
        opB    = 32'd2;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        $display("op rst_mid    busy=%0b done=%0b result=%h", busy, done, result);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) lat++;
        end
        check("rst_no_done", 32'(lat), 32'd0);

        run_op("mul_6x7", 3'b000, 32'd6, 32'd7, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
